// File: rtl/shift_register_burst_pkg.sv
// Shared definitions for the shift_register_burst slice.
//   MODE_W        width of the shift mode code
//   shift_mode_e  encoding of the eight shift/rotate modes
package shift_register_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_ASR  = 3'd5,
        MODE_SHL0 = 3'd6,
        MODE_RSVD = 3'd7
    } shift_mode_e;

endpackage

// File: rtl/shift_register_burst_if.sv
// Control/data bundle of the burst shift register.
//   master: drives load/data_in/shift/mode/ser_in/start/count,
//           observes busy/done/data_out/ser_out
//   slave : the register block itself
interface shift_register_burst_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 8
);
    import shift_register_pkg::*;

    logic              load;
    logic [WIDTH-1:0]  data_in;
    logic              shift;
    logic [MODE_W-1:0] mode;
    logic [STEP-1:0]   ser_in;
    logic              start;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  data_out;
    logic [STEP-1:0]   ser_out;

    modport master (
        output load, data_in, shift, mode, ser_in, start, count,
        input  busy, done, data_out, ser_out
    );

    modport slave (
        input  load, data_in, shift, mode, ser_in, start, count,
        output busy, done, data_out, ser_out
    );

endinterface

// File: rtl/shift_register_burst_step_unit.sv
// One shift/rotate step, purely combinational.
//   cur_reg  : present register value
//   mode     : step mode
//   ser_in   : fill bits for SHL/SHR
//   next_reg : register value after the step
//   out_bits : bits leaving the register
//   moved    : high when the mode really moves bits (HOLD/reserved keep ser_out)
module shift_register_step_unit
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] cur_reg,
    input  shift_mode_e      mode,
    input  logic [STEP-1:0]  ser_in,
    output logic [WIDTH-1:0] next_reg,
    output logic [STEP-1:0]  out_bits,
    output logic             moved
);

    // Step result selected by mode; left moves drop the top bits, right moves the bottom bits.
    always_comb begin
        next_reg = cur_reg;
        out_bits = {STEP{1'b0}};
        moved    = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_reg = {cur_reg[WIDTH-STEP-1:0], ser_in};
                out_bits = cur_reg[WIDTH-1:WIDTH-STEP];
                moved    = 1'b1;
            end
            MODE_SHR: begin
                next_reg = {ser_in, cur_reg[WIDTH-1:STEP]};
                out_bits = cur_reg[STEP-1:0];
                moved    = 1'b1;
            end
            MODE_ROL: begin
                next_reg = {cur_reg[WIDTH-STEP-1:0], cur_reg[WIDTH-1:WIDTH-STEP]};
                out_bits = cur_reg[WIDTH-1:WIDTH-STEP];
                moved    = 1'b1;
            end
            MODE_ROR: begin
                next_reg = {cur_reg[STEP-1:0], cur_reg[WIDTH-1:STEP]};
                out_bits = cur_reg[STEP-1:0];
                moved    = 1'b1;
            end
            MODE_ASR: begin
                next_reg = {{STEP{cur_reg[WIDTH-1]}}, cur_reg[WIDTH-1:STEP]};
                out_bits = cur_reg[STEP-1:0];
                moved    = 1'b1;
            end
            MODE_SHL0: begin
                next_reg = {cur_reg[WIDTH-STEP-1:0], {STEP{1'b0}}};
                out_bits = cur_reg[WIDTH-1:WIDTH-STEP];
                moved    = 1'b1;
            end
            default: begin
                next_reg = cur_reg;
                out_bits = {STEP{1'b0}};
                moved    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_register_burst.sv
// Parametrised load/shift register with serial lanes and a counted burst engine.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of shift_register_burst_if (load, data_in, shift, mode,
//           ser_in, start, count in; busy, done, data_out, ser_out out)
module shift_register_burst
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_register_burst_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] data_r,      data_nxt_s;
    logic [STEP-1:0]  ser_out_r,   ser_out_nxt_s;
    logic             busy_r,      busy_nxt_s;
    logic             done_r,      done_nxt_s;
    logic [CNT_W-1:0] remaining_r, remaining_nxt_s;
    shift_mode_e      mode_r,      mode_nxt_s;

    shift_mode_e      live_mode_s;
    shift_mode_e      step_mode_s;
    logic [WIDTH-1:0] step_reg_s;
    logic [STEP-1:0]  step_bits_s;
    logic             step_moved_s;

    // A running burst uses the mode captured at start; otherwise the live mode drives the step.
    always_comb begin
        live_mode_s = shift_mode_e'(bus.mode);
        if (busy_r) begin
            step_mode_s = mode_r;
        end else begin
            step_mode_s = live_mode_s;
        end
    end

    shift_register_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .cur_reg  (data_r),
        .mode     (step_mode_s),
        .ser_in   (bus.ser_in),
        .next_reg (step_reg_s),
        .out_bits (step_bits_s),
        .moved    (step_moved_s)
    );

    // Next-state decode, priority load > burst step > start > shift.
    always_comb begin
        data_nxt_s      = data_r;
        ser_out_nxt_s   = ser_out_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        remaining_nxt_s = remaining_r;
        mode_nxt_s      = mode_r;
        if (bus.load) begin
            // Load aborts any burst silently (no done).
            data_nxt_s      = bus.data_in;
            busy_nxt_s      = 1'b0;
            remaining_nxt_s = CNT_ZERO;
        end else if (busy_r) begin
            if (step_moved_s) begin
                data_nxt_s    = step_reg_s;
                ser_out_nxt_s = step_bits_s;
            end else begin
                data_nxt_s    = data_r;
            end
            remaining_nxt_s = remaining_r - CNT_ONE;
            if (remaining_r == CNT_ONE) begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end else begin
                busy_nxt_s = 1'b1;
            end
        end else if (bus.start) begin
            if (bus.count == CNT_ZERO) begin
                // Empty burst: just acknowledge with done.
                done_nxt_s = 1'b1;
            end else begin
                busy_nxt_s      = 1'b1;
                remaining_nxt_s = bus.count;
                mode_nxt_s      = live_mode_s;
            end
        end else if (bus.shift) begin
            if (step_moved_s) begin
                data_nxt_s    = step_reg_s;
                ser_out_nxt_s = step_bits_s;
            end else begin
                data_nxt_s    = data_r;
            end
        end else begin
            data_nxt_s = data_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r      <= {WIDTH{1'b0}};
            ser_out_r   <= {STEP{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            remaining_r <= CNT_ZERO;
            mode_r      <= MODE_HOLD;
        end else begin
            data_r      <= data_nxt_s;
            ser_out_r   <= ser_out_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            remaining_r <= remaining_nxt_s;
            mode_r      <= mode_nxt_s;
        end
    end

    assign bus.data_out = data_r;
    assign bus.ser_out  = ser_out_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_shift_register_burst.sv
// Scoreboard bench for shift_register_burst: one instance with STEP=1 and one
// with STEP=2. Stimulus pushes the expected outputs for the next clock edge;
// the monitor pops and compares them on the following falling edge.
module tb_shift_register_burst;

    logic clk;
    logic reset;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    shift_register_burst_if #(.WIDTH(8), .STEP(1), .CNT_W(8)) bus1 ();
    shift_register_burst_if #(.WIDTH(8), .STEP(2), .CNT_W(8)) bus2 ();

    shift_register_burst #(.WIDTH(8), .STEP(1), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    shift_register_burst #(.WIDTH(8), .STEP(2), .CNT_W(8)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic [7:0] data;
        logic [1:0] ser;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_dut(int dut, string nm, logic [7:0] d, logic [1:0] s, logic b, logic dn);
        logic [7:0] a_d;
        logic [1:0] a_s;
        logic       a_b;
        logic       a_dn;
        if (dut == 1) begin
            a_d  = bus1.data_out;
            a_s  = {1'b0, bus1.ser_out};
            a_b  = bus1.busy;
            a_dn = bus1.done;
        end else begin
            a_d  = bus2.data_out;
            a_s  = bus2.ser_out;
            a_b  = bus2.busy;
            a_dn = bus2.done;
        end
        chk({nm, "/data_out"}, a_d, d);
        chk({nm, "/ser_out"}, {6'd0, a_s}, {6'd0, s});
        chk({nm, "/busy"}, {7'd0, a_b}, {7'd0, b});
        chk({nm, "/done"}, {7'd0, a_dn}, {7'd0, dn});
    endtask

    // Monitor: compare every entry due at this falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: stale entry, due cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
                chk_dut(e.dut, e.name, e.data, e.ser, e.busy, e.done);
            end
        end
    end

    task automatic push_exp(int dut, string nm, logic [7:0] d, logic [1:0] s, logic b, logic dn);
        exp_t e;
        e.cyc  = cyc + 1;
        e.dut  = dut;
        e.name = nm;
        e.data = d;
        e.ser  = s;
        e.busy = b;
        e.done = dn;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.load = 1'b0; bus1.data_in = 8'h00; bus1.shift = 1'b0; bus1.mode = 3'd0;
        bus1.ser_in = 1'b0; bus1.start = 1'b0; bus1.count = 8'd0;
        bus2.load = 1'b0; bus2.data_in = 8'h00; bus2.shift = 1'b0; bus2.mode = 3'd0;
        bus2.ser_in = 2'b00; bus2.start = 1'b0; bus2.count = 8'd0;
    endtask

    initial begin
        logic [7:0] d_tab [8];
        logic [7:0] a5;
        d_tab = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
        a5    = 8'hA5;

        reset = 1'b1;
        idle_inputs();
        #1 reset = 1'b0;
        #1;
        chk_dut(1, "rst_init1", 8'h00, 2'b00, 1'b0, 1'b0);
        chk_dut(2, "rst_init2", 8'h00, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        push_exp(1, "rst_rel1", 8'h00, 2'b00, 1'b0, 1'b0);
        push_exp(2, "rst_rel2", 8'h00, 2'b00, 1'b0, 1'b0);
        tick();

        // Single steps, STEP=1: ASR twice, SHL with fill, reserved and HOLD.
        bus1.load = 1'b1; bus1.data_in = 8'hB4;
        push_exp(1, "t2_load", 8'hB4, 2'b00, 1'b0, 1'b0);
        tick();
        bus1.load = 1'b0; bus1.shift = 1'b1; bus1.mode = 3'd5;
        push_exp(1, "t2_asr1", 8'hDA, 2'b00, 1'b0, 1'b0);
        tick();
        push_exp(1, "t2_asr2", 8'hED, 2'b00, 1'b0, 1'b0);
        tick();
        bus1.mode = 3'd1; bus1.ser_in = 1'b1;
        push_exp(1, "shl_fill", 8'hDB, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.mode = 3'd7; bus1.ser_in = 1'b0;
        push_exp(1, "t6_rsvd", 8'hDB, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.mode = 3'd0;
        push_exp(1, "hold", 8'hDB, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.shift = 1'b0;

        // Burst ROL x4, STEP=2; start/shift/mode/count wiggled while busy.
        bus2.load = 1'b1; bus2.data_in = 8'hC3;
        push_exp(2, "t3_load", 8'hC3, 2'b00, 1'b0, 1'b0);
        tick();
        bus2.load = 1'b0; bus2.start = 1'b1; bus2.count = 8'd4; bus2.mode = 3'd3;
        push_exp(2, "t3_start", 8'hC3, 2'b00, 1'b1, 1'b0);
        tick();
        bus2.count = 8'd2; bus2.mode = 3'd1; bus2.shift = 1'b1; bus2.ser_in = 2'b01;
        push_exp(2, "t3_rol1", 8'h0F, 2'b11, 1'b1, 1'b0);
        tick();
        push_exp(2, "t3_rol2", 8'h3C, 2'b00, 1'b1, 1'b0);
        tick();
        push_exp(2, "t3_rol3", 8'hF0, 2'b00, 1'b1, 1'b0);
        tick();
        bus2.start = 1'b0; bus2.shift = 1'b0; bus2.mode = 3'd0; bus2.count = 8'd0;
        push_exp(2, "t3_rol4", 8'hC3, 2'b11, 1'b0, 1'b1);
        tick();
        // Back-to-back: start in the done cycle, ROR x1.
        bus2.start = 1'b1; bus2.count = 8'd1; bus2.mode = 3'd4;
        push_exp(2, "b2b_start", 8'hC3, 2'b11, 1'b1, 1'b0);
        tick();
        bus2.start = 1'b0; bus2.mode = 3'd0; bus2.count = 8'd0;
        push_exp(2, "b2b_ror", 8'hF0, 2'b11, 1'b0, 1'b1);
        tick();
        push_exp(2, "b2b_idle", 8'hF0, 2'b11, 1'b0, 1'b0);
        tick();

        // Serialiser: SHL0 x8 of A5.
        bus1.load = 1'b1; bus1.data_in = 8'hA5;
        push_exp(1, "t4_load", 8'hA5, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.load = 1'b0; bus1.start = 1'b1; bus1.count = 8'd8; bus1.mode = 3'd6;
        push_exp(1, "t4_start", 8'hA5, 2'b01, 1'b1, 1'b0);
        tick();
        bus1.start = 1'b0; bus1.mode = 3'd0; bus1.count = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            push_exp(1, $sformatf("t4_step%0d", k), d_tab[k-1], {1'b0, a5[8-k]},
                     (k < 8) ? 1'b1 : 1'b0, (k == 8) ? 1'b1 : 1'b0);
            tick();
        end

        // Empty burst.
        bus1.load = 1'b1; bus1.data_in = 8'h5A;
        push_exp(1, "t6_load", 8'h5A, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.load = 1'b0; bus1.start = 1'b1; bus1.count = 8'd0; bus1.mode = 3'd1;
        push_exp(1, "t6_cnt0", 8'h5A, 2'b01, 1'b0, 1'b1);
        tick();
        bus1.start = 1'b0; bus1.mode = 3'd0;
        push_exp(1, "t6_cnt0_after", 8'h5A, 2'b01, 1'b0, 1'b0);
        tick();

        // Abort: SHR x6 with ser_in=1, load 3C in the 3rd busy cycle.
        bus1.start = 1'b1; bus1.count = 8'd6; bus1.mode = 3'd2; bus1.ser_in = 1'b1;
        push_exp(1, "t5_start", 8'h5A, 2'b01, 1'b1, 1'b0);
        tick();
        bus1.start = 1'b0; bus1.mode = 3'd0; bus1.count = 8'd0;
        push_exp(1, "t5_shr1", 8'hAD, 2'b00, 1'b1, 1'b0);
        tick();
        push_exp(1, "t5_shr2", 8'hD6, 2'b01, 1'b1, 1'b0);
        tick();
        bus1.load = 1'b1; bus1.data_in = 8'h3C;
        push_exp(1, "t5_abort", 8'h3C, 2'b01, 1'b0, 1'b0);
        tick();
        bus1.load = 1'b0; bus1.ser_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_exp(1, $sformatf("t5_nodone%0d", k), 8'h3C, 2'b01, 1'b0, 1'b0);
            tick();
        end

        // Reset asserted mid-burst clears at once.
        bus2.start = 1'b1; bus2.count = 8'd5; bus2.mode = 3'd3;
        push_exp(2, "t1_start", 8'hF0, 2'b11, 1'b1, 1'b0);
        tick();
        bus2.start = 1'b0; bus2.mode = 3'd0; bus2.count = 8'd0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk_dut(2, "t1_async2", 8'h00, 2'b00, 1'b0, 1'b0);
        chk_dut(1, "t1_async1", 8'h00, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        push_exp(2, "t1_rel", 8'h00, 2'b00, 1'b0, 1'b0);
        tick();
        push_exp(2, "t1_nodone", 8'h00, 2'b00, 1'b0, 1'b0);
        tick();

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries never compared", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
